// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// The ALU result is captured into a single response register drained through a valid/ready handshake.
module alu_arbiter #(
  parameter int SIZE = 32,
  parameter int C    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [SIZE-1:0] req0_in1,
  input  logic [SIZE-1:0] req0_in2,
  input  logic [SIZE-1:0] req1_in1,
  input  logic [SIZE-1:0] req1_in2,
  input  logic [C:0]      req0_shamt,
  input  logic [C:0]      req1_shamt,
  input  logic [C-1:0]    req0_control,
  input  logic [C-1:0]    req1_control,
  output logic [SIZE-1:0] alu_in1,
  output logic [SIZE-1:0] alu_in2,
  output logic [C:0]      alu_shamt,
  output logic [C-1:0]    alu_control,
  input  logic [SIZE-1:0] alu_out,
  input  logic [2:0]      alu_flag,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [SIZE-1:0] rsp_out,
  output logic [2:0]      rsp_flag
);

  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic            prio_r;
  logic            acc_s;
  logic            gnt_any_s;
  logic            gnt_id_s;
  logic            sel_s;
  logic            accept_s;
  logic            rsp_id_r;
  logic [SIZE-1:0] rsp_out_r;
  logic [2:0]      rsp_flag_r;

  // Arbitration, accept decision and next-state logic
  always_comb begin
    acc_s       = (state_r == IDLE) || rsp_ready;
    gnt_any_s   = |req_valid;
    gnt_id_s    = 1'b0;
    state_nxt_s = state_r;
    req_ready   = 2'b00;
    if (req_valid == 2'b11) begin
      gnt_id_s = prio_r;
    end else if (req_valid[1]) begin
      gnt_id_s = 1'b1;
    end else begin
      gnt_id_s = 1'b0;
    end
    // Reset gates the accept so nothing is handshaken while the block is held in reset
    accept_s = rst && acc_s && gnt_any_s;
    sel_s    = gnt_any_s ? gnt_id_s : prio_r;
    if (accept_s) begin
      req_ready = gnt_id_s ? 2'b10 : 2'b01;
    end else begin
      req_ready = 2'b00;
    end
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HOLD: begin
        if (accept_s) begin
          state_nxt_s = HOLD;
        end else if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand mux towards the shared ALU
  always_comb begin
    alu_in1     = req0_in1;
    alu_in2     = req0_in2;
    alu_shamt   = req0_shamt;
    alu_control = req0_control;
    if (sel_s) begin
      alu_in1     = req1_in1;
      alu_in2     = req1_in2;
      alu_shamt   = req1_shamt;
      alu_control = req1_control;
    end else begin
      alu_in1     = req0_in1;
      alu_in2     = req0_in2;
      alu_shamt   = req0_shamt;
      alu_control = req0_control;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Response capture and round-robin pointer; payload holds on drain
  always_ff @(posedge clk) begin
    if (!rst) begin
      prio_r     <= 1'b0;
      rsp_id_r   <= 1'b0;
      rsp_out_r  <= '0;
      rsp_flag_r <= 3'b000;
    end else if (accept_s) begin
      prio_r     <= ~gnt_id_s;
      rsp_id_r   <= gnt_id_s;
      rsp_out_r  <= alu_out;
      rsp_flag_r <= alu_flag;
    end else begin
      prio_r     <= prio_r;
      rsp_id_r   <= rsp_id_r;
      rsp_out_r  <= rsp_out_r;
      rsp_flag_r <= rsp_flag_r;
    end
  end

  assign rsp_valid = (state_r == HOLD);
  assign rsp_id    = rsp_id_r;
  assign rsp_out   = rsp_out_r;
  assign rsp_flag  = rsp_flag_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Table-driven bench for alu_arbiter with a small ALU model and a response scoreboard.
module tb_alu_arbiter;
  localparam int SIZE = 32;
  localparam int C    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [SIZE-1:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [C:0]      req0_shamt, req1_shamt;
  logic [C-1:0]    req0_control, req1_control;
  logic [SIZE-1:0] alu_in1, alu_in2, alu_out;
  logic [C:0]      alu_shamt;
  logic [C-1:0]    alu_control;
  logic [2:0]      alu_flag;
  logic            rsp_valid, rsp_ready, rsp_id;
  logic [SIZE-1:0] rsp_out;
  logic [2:0]      rsp_flag;

  always #5 clk = ~clk;

  alu_arbiter #(.SIZE(SIZE), .C(C)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_in1(req0_in1), .req0_in2(req0_in2), .req1_in1(req1_in1), .req1_in2(req1_in2),
    .req0_shamt(req0_shamt), .req1_shamt(req1_shamt),
    .req0_control(req0_control), .req1_control(req1_control),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_shamt(alu_shamt), .alu_control(alu_control),
    .alu_out(alu_out), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_flag(rsp_flag)
  );

  // Shared ALU stand-in: flags are {zero, negative, carry}
  function automatic logic [SIZE+2:0] alu_fn(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                             input logic [C:0] sh, input logic [C-1:0] op);
    logic [SIZE:0]   wide;
    logic [SIZE-1:0] res;
    logic            cy;
    wide = '0;
    res  = '0;
    cy   = 1'b0;
    case (op)
      4'b0000: begin
        wide = {1'b0, a} + {1'b0, b};
        res  = wide[SIZE-1:0];
        cy   = wide[SIZE];
      end
      4'b0101: res = a << sh;
      4'b1111: res = $unsigned($signed(a) >>> b[4:0]);
      default: res = a ^ b;
    endcase
    return {(res == '0), res[SIZE-1], cy, res};
  endfunction

  always_comb {alu_flag, alu_out} = alu_fn(alu_in1, alu_in2, alu_shamt, alu_control);

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] a0, b0;
    logic [4:0]  s0;
    logic [3:0]  c0;
    logic [31:0] a1, b1;
    logic [4:0]  s1;
    logic [3:0]  c1;
    logic        rdy;
    logic [1:0]  exp_ready;
    logic [31:0] exp_out;
    logic [2:0]  exp_flag;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] out;
    logic [2:0]  flag;
  } rsp_t;

  vec_t        vecs[20];
  rsp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        m_valid, m_id;
  logic [31:0] m_out;
  logic [2:0]  m_flag;

  function automatic vec_t mkv(input logic [1:0] valid,
                               input logic [31:0] a0, input logic [31:0] b0, input logic [4:0] s0, input logic [3:0] c0,
                               input logic [31:0] a1, input logic [31:0] b1, input logic [4:0] s1, input logic [3:0] c1,
                               input logic rdy, input logic [1:0] er, input logic [31:0] eo, input logic [2:0] ef);
    vec_t v;
    v.valid = valid; v.a0 = a0; v.b0 = b0; v.s0 = s0; v.c0 = c0;
    v.a1 = a1; v.b1 = b1; v.s1 = s1; v.c1 = c1;
    v.rdy = rdy; v.exp_ready = er; v.exp_out = eo; v.exp_flag = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    rsp_t e;
    @(negedge clk);
    rst = 1'b1;
    req_valid = v.valid;
    req0_in1 = v.a0; req0_in2 = v.b0; req0_shamt = v.s0; req0_control = v.c0;
    req1_in1 = v.a1; req1_in2 = v.b1; req1_shamt = v.s1; req1_control = v.c1;
    rsp_ready = v.rdy;
    #1;
    chk($sformatf("req_ready[%0d]", idx), {30'd0, req_ready}, {30'd0, v.exp_ready});
    if (v.exp_ready != 2'b00) begin
      chk($sformatf("alu_in1[%0d]", idx), alu_in1, v.exp_ready[1] ? v.a1 : v.a0);
      chk($sformatf("alu_control[%0d]", idx), {28'd0, alu_control}, {28'd0, (v.exp_ready[1] ? v.c1 : v.c0)});
      sb_q.push_back('{id: v.exp_ready[1], out: v.exp_out, flag: v.exp_flag});
    end else if (m_valid && v.rdy) begin
      m_valid = 1'b0;
    end else begin
      m_valid = m_valid;
    end
    @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      m_valid = 1'b1; m_id = e.id; m_out = e.out; m_flag = e.flag;
    end
    chk($sformatf("rsp_valid[%0d]", idx), {31'd0, rsp_valid}, {31'd0, m_valid});
    chk($sformatf("rsp_id[%0d]", idx), {31'd0, rsp_id}, {31'd0, m_id});
    chk($sformatf("rsp_out[%0d]", idx), rsp_out, m_out);
    chk($sformatf("rsp_flag[%0d]", idx), {29'd0, rsp_flag}, {29'd0, m_flag});
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_id"}, {31'd0, rsp_id}, 32'd0);
    chk({tag, "_rsp_out"}, rsp_out, 32'd0);
    chk({tag, "_rsp_flag"}, {29'd0, rsp_flag}, 32'd0);
  endtask

  initial begin
    vecs[0]  = mkv(2'b01, 32'd5,   32'd7,  5'd0, 4'd0, 32'd1, 32'd2, 5'd0, 4'd0, 1'b1, 2'b01, 32'd12, 3'b000);
    vecs[1]  = mkv(2'b10, 32'd10,  32'd20, 5'd0, 4'd0, 32'd1, 32'd2, 5'd0, 4'd0, 1'b1, 2'b10, 32'd3,  3'b000);
    vecs[2]  = mkv(2'b11, 32'd10,  32'd20, 5'd0, 4'd0, 32'd1, 32'd2, 5'd0, 4'd0, 1'b1, 2'b01, 32'd30, 3'b000);
    vecs[3]  = mkv(2'b11, 32'd10,  32'd20, 5'd0, 4'd0, 32'd1, 32'd2, 5'd0, 4'd0, 1'b1, 2'b10, 32'd3,  3'b000);
    vecs[4]  = mkv(2'b11, 32'd10,  32'd20, 5'd0, 4'd0, 32'd1, 32'd2, 5'd0, 4'd0, 1'b1, 2'b01, 32'd30, 3'b000);
    vecs[5]  = mkv(2'b11, 32'd10,  32'd20, 5'd0, 4'd0, 32'd1, 32'd2, 5'd0, 4'd0, 1'b1, 2'b10, 32'd3,  3'b000);
    vecs[6]  = mkv(2'b11, 32'd10,  32'd20, 5'd0, 4'd0, 32'd1, 32'd2, 5'd0, 4'd0, 1'b0, 2'b00, 32'd0,  3'b000);
    vecs[7]  = mkv(2'b11, 32'd10,  32'd20, 5'd0, 4'd0, 32'd1, 32'd2, 5'd0, 4'd0, 1'b0, 2'b00, 32'd0,  3'b000);
    vecs[8]  = mkv(2'b11, 32'd10,  32'd20, 5'd0, 4'd0, 32'd1, 32'd2, 5'd0, 4'd0, 1'b0, 2'b00, 32'd0,  3'b000);
    vecs[9]  = mkv(2'b11, 32'd10,  32'd20, 5'd0, 4'd0, 32'd1, 32'd2, 5'd0, 4'd0, 1'b1, 2'b01, 32'd30, 3'b000);
    vecs[10] = mkv(2'b10, 32'd10,  32'd20, 5'd0, 4'd0, 32'd1, 32'd0, 5'd4, 4'b0101, 1'b1, 2'b10, 32'd16, 3'b000);
    vecs[11] = mkv(2'b10, 32'd10,  32'd20, 5'd0, 4'd0, 32'h8000_0000, 32'd4, 5'd0, 4'b1111, 1'b1, 2'b10, 32'hF800_0000, 3'b010);
    vecs[12] = mkv(2'b00, 32'd10,  32'd20, 5'd0, 4'd0, 32'd1, 32'd2, 5'd0, 4'd0, 1'b1, 2'b00, 32'd0,  3'b000);
    vecs[13] = mkv(2'b00, 32'd10,  32'd20, 5'd0, 4'd0, 32'd1, 32'd2, 5'd0, 4'd0, 1'b0, 2'b00, 32'd0,  3'b000);
    vecs[14] = mkv(2'b01, 32'd100, 32'd23, 5'd0, 4'd0, 32'd1, 32'd2, 5'd0, 4'd0, 1'b0, 2'b01, 32'd123, 3'b000);
    vecs[15] = mkv(2'b10, 32'd10,  32'd20, 5'd0, 4'd0, 32'd1, 32'd2, 5'd0, 4'd0, 1'b0, 2'b00, 32'd0,  3'b000);
    vecs[16] = mkv(2'b00, 32'd10,  32'd20, 5'd0, 4'd0, 32'd1, 32'd2, 5'd0, 4'd0, 1'b0, 2'b00, 32'd0,  3'b000);
    vecs[17] = mkv(2'b11, 32'd10,  32'd20, 5'd0, 4'd0, 32'd1, 32'd2, 5'd0, 4'd0, 1'b1, 2'b01, 32'd30, 3'b000);
    vecs[18] = mkv(2'b11, 32'd10,  32'd20, 5'd0, 4'd0, 32'd1, 32'd2, 5'd0, 4'd0, 1'b1, 2'b10, 32'd3,  3'b000);
    vecs[19] = mkv(2'b00, 32'd10,  32'd20, 5'd0, 4'd0, 32'd1, 32'd2, 5'd0, 4'd0, 1'b1, 2'b00, 32'd0,  3'b000);

    rst = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
    req0_in1 = 32'd10; req0_in2 = 32'd20; req0_shamt = 5'd0; req0_control = 4'd0;
    req1_in1 = 32'd1;  req1_in2 = 32'd2;  req1_shamt = 5'd0; req1_control = 4'd0;
    m_valid = 1'b0; m_id = 1'b0; m_out = 32'd0; m_flag = 3'b000;

    // Power-on reset with both requesters asking: no handshake may occur
    repeat (2) begin
      @(negedge clk);
      chk("reset_req_ready", {30'd0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    check_reset_state("por");

    for (int i = 0; i < 17; i++) apply(vecs[i], i);

    // Reset while a response is held under backpressure; prio is 1 at this point
    @(negedge clk);
    rst = 1'b0; req_valid = 2'b11; rsp_ready = 1'b0;
    #1;
    chk("midrst_req_ready", {30'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    check_reset_state("midrst");
    sb_q.delete();
    m_valid = 1'b0; m_id = 1'b0; m_out = 32'd0; m_flag = 3'b000;

    for (int i = 17; i < 20; i++) apply(vecs[i], i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter SIZE, default 32: datapath width of operands and result.
REQ-002 Parameter C, default 4: control width; shamt width is C+1.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low (rst==0 at a rising edge of clk resets the block).
REQ-005 req_valid  in  2  per-requester request valid; bit i belongs to requester i.
REQ-006 req_ready  out  2  per-requester accept; a transfer on requester i occurs when req_valid[i] && req_ready[i] at a rising edge.
REQ-007 req0_in1, req0_in2, req1_in1, req1_in2  in  SIZE  operands of requesters 0 and 1.
REQ-008 req0_shamt, req1_shamt  in  C+1  shift amounts of requesters 0 and 1.
REQ-009 req0_control, req1_control  in  C  ALU opcodes of requesters 0 and 1.
REQ-010 alu_in1, alu_in2  out  SIZE  operands driven to the shared ALU.
REQ-011 alu_shamt  out  C+1, alu_control  out  C  shift amount and opcode to the shared ALU.
REQ-012 alu_out  in  SIZE, alu_flag  in  3  combinational result and flags returned by the ALU.
REQ-013 rsp_valid  out  1  response register holds a result.
REQ-014 rsp_ready  in  1  consumer accepts; a response transfer occurs when rsp_valid && rsp_ready at a rising edge.
REQ-015 rsp_id  out  1, rsp_out  out  SIZE, rsp_flag  out  3  requester index, captured result, and flags.

Function
REQ-016 Two states: IDLE (response register empty) and HOLD (response register full).
REQ-017 Accept enable acc = !rsp_valid || rsp_ready, so a new request is accepted in the same cycle the old response drains.
REQ-018 Round-robin grant: pointer prio (1 bit) names the favoured requester; if both valid, grant prio; if one valid, grant it.
REQ-019 req_ready[i] is combinational: 1 only for the granted requester when acc==1; at most one bit is set per cycle.
REQ-020 ALU inputs mux combinationally from the granted requester; when nothing is granted, drive the requester-prio fields (no X).
REQ-021 On an accept from requester i: rsp_out<=alu_out, rsp_flag<=alu_flag, rsp_id<=i, rsp_valid<=1, prio<=~i; latency from accept to rsp_valid is exactly 1 cycle.
REQ-022 Response drains without a new accept: rsp_valid<=0, state->IDLE; rsp_out/rsp_flag/rsp_id hold their last values.
REQ-023 Backpressure: while rsp_valid && !rsp_ready, req_ready==2'b00 and all rsp_* hold stable.
REQ-024 prio changes only on an accept; a requester that drops req_valid before being granted loses nothing and causes no state change.
REQ-025 Sustained throughput: one result per cycle while rsp_ready==1; with both requesters held valid, grants strictly alternate 0,1,0,1...
REQ-026 No operand, opcode, or flag interpretation is done in this block; the ALU is treated as purely combinational.

Reset
REQ-027 On rst==0 at a rising edge: state IDLE, rsp_valid=0, rsp_id=0, rsp_out=0, rsp_flag=0, prio=0.
REQ-028 Reset overrides any in-flight accept or drain in the same cycle; a held response is discarded.
REQ-029 While rst==0, req_ready==2'b00.

Verification
REQ-030 Reset, then req_valid=01, req0 in1=5, in2=7, control=0000, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_out=12, rsp_flag=000.
REQ-031 Both requesters valid for 4 cycles, rsp_ready=1 -> grant order 0,1,0,1; rsp_id sequence 0,1,0,1 one cycle later.
REQ-032 Response held with rsp_ready=0 for 3 cycles while req_valid=11 -> req_ready=00 and rsp_* unchanged; rsp_ready=1 -> same-cycle accept of the prio requester.
REQ-033 req1 control=0101, shamt=4, in1=1 -> rsp_out=16, rsp_id=1; req1 control=1111, in1=0x80000000, in2=4 -> rsp_out=0xF8000000, flag[1]=1.
REQ-034 rst asserted while rsp_valid=1 and rsp_ready=0 -> next cycle rsp_valid=0, rsp_out=0, prio=0; the first grant after reset goes to requester 0 when both are valid.
